// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// A launch latches the operands and loads a cycle counter. HI/LO are written
// only when the counter expires, so a reset mid-operation leaves no partial result.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_sel,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   hi, lo, hi_nxt, lo_nxt;
    logic [WIDTH-1:0]   a_p0, b_p0, a_nxt, b_nxt;
    logic [1:0]         op_p0, op_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] divres;

    // Full-width product. Extending both operands to 2*WIDTH (sign or zero)
    // makes the truncated 2*WIDTH product exact for both mult and multu.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic sgn,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] xe;
        logic signed [2*WIDTH-1:0] ye;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}. Signed division runs on magnitudes:
    // quotient truncates toward zero, remainder takes the dividend's sign.
    // most-negative / -1 falls out naturally: magnitude 2^(W-1) re-read as
    // two's complement is most-negative again, remainder 0.
    // A zero divisor is replaced by 1 only to keep the divider defined;
    // the caller discards that result.
    function automatic logic [2*WIDTH-1:0] div_full(input logic sgn,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic             xn, yn;
        logic [WIDTH-1:0] ux, uy, q, r;
        xn = sgn & x[WIDTH-1];
        yn = sgn & y[WIDTH-1];
        ux = xn ? (~x + 1'b1) : x;
        uy = yn ? (~y + 1'b1) : y;
        if (uy == '0) uy = {{(WIDTH-1){1'b0}}, 1'b1};
        q = ux / uy;
        r = ux % uy;
        if (xn ^ yn) q = ~q + 1'b1;
        if (xn)      r = ~r + 1'b1;
        return {r, q};
    endfunction

    // Next-state logic: launch / mthi-mtlo in IDLE, countdown and HI/LO commit in RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        a_nxt     = a_p0;
        b_nxt     = b_p0;
        op_nxt    = op_p0;
        prod      = mul_full(~op_p0[0], a_p0, b_p0);
        divres    = div_full(~op_p0[0], a_p0, b_p0);
        if (state == IDLE) begin
            if (start) begin
                a_nxt     = a;
                b_nxt     = b;
                op_nxt    = op;
                cnt_nxt   = op[1] ? DIV_N : MULT_N;
                state_nxt = RUN;
            end else if (hilo_we) begin
                if (hilo_wsel) hi_nxt = wdata;
                else           lo_nxt = wdata;
            end
        end else begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state_nxt = IDLE;
                if (!op_p0[1]) begin
                    {hi_nxt, lo_nxt} = prod;
                end else if (b_p0 != '0) begin
                    {hi_nxt, lo_nxt} = divres;
                end
            end
        end
    end

    // State, counter, operand latches and HI/LO; reset discards any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            a_p0  <= a_nxt;
            b_p0  <= b_nxt;
            op_p0 <= op_nxt;
        end
    end

    // RUN is held exactly while the counter is non-zero, so busy comes straight from a flop.
    assign busy   = (state == RUN);
    assign result = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset, start, hilo_we, hilo_wsel, rd_sel, busy;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata, result;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [1:0]  m_op;
    int          m_left;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_we(hilo_we), .hilo_wsel(hilo_wsel), .wdata(wdata),
        .rd_sel(rd_sel), .busy(busy), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // apply the finished operation to the model using plain integer arithmetic
    task automatic model_finish();
        int              sa, sb;
        longint          ps;
        longint unsigned pu;
        sa = m_a;
        sb = m_b;
        case (m_op)
            2'b00: begin
                ps = longint'(sa) * longint'(sb);
                m_hi = ps[63:32];
                m_lo = ps[31:0];
            end
            2'b01: begin
                pu = {32'b0, m_a} * {32'b0, m_b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            2'b10: begin
                if (m_b != 0) begin
                    if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'h0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            default: begin
                if (m_b != 0) begin
                    m_lo = m_a / m_b;
                    m_hi = m_a % m_b;
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
    endtask

    // one clock: advance the model with the current inputs, then compare busy/result
    task automatic cycle();
        if (m_left == 0) begin
            if (start) begin
                m_a = a; m_b = b; m_op = op;
                m_left = op[1] ? DC : MC;
            end else if (hilo_we) begin
                if (hilo_wsel) m_hi = wdata;
                else           m_lo = wdata;
            end
        end else begin
            m_left--;
            if (m_left == 0) model_finish();
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("result", result, rd_sel ? m_hi : m_lo);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        cycle();
        start = 1'b0;
    endtask

    task automatic mt(input logic sel, input logic [31:0] d);
        hilo_we = 1'b1; hilo_wsel = sel; wdata = d;
        cycle();
        hilo_we = 1'b0;
    endtask

    // read HI and LO through rd_sel between clock edges and compare with constants
    task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        rd_sel = 1'b1; #1;
        chk({tag, "_hi"}, result, eh);
        rd_sel = 1'b0; #1;
        chk({tag, "_lo"}, result, el);
    endtask

    initial begin
        reset = 1'b1; start = 0; op = 0; a = 0; b = 0;
        hilo_we = 0; hilo_wsel = 0; wdata = 0; rd_sel = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        expect_hilo("rst", 32'h0, 32'h0);

        // mult -2 * 3
        launch(2'b00, 32'hFFFF_FFFE, 32'd3);
        run(MC);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // multu max * max
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MC);
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // div -7 / 2
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        run(DC);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // overflow case and a plain divu
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(DC);
        expect_hilo("divovf", 32'h0, 32'h8000_0000);
        launch(2'b11, 32'd100, 32'd7);
        run(DC);
        expect_hilo("divu", 32'd2, 32'd14);

        // divide by zero keeps HI/LO
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        launch(2'b11, 32'd7, 32'd0);
        run(DC);
        expect_hilo("div0", 32'h11, 32'h22);

        // start and mthi during busy are ignored
        launch(2'b00, 32'd6, 32'd7);
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
        hilo_we = 1'b1; hilo_wsel = 1'b1; wdata = 32'hAA;
        cycle();
        start = 1'b0; hilo_we = 1'b0;
        run(MC - 1);
        expect_hilo("ignore", 32'h0, 32'd42);

        // asynchronous reset in the third busy cycle
        launch(2'b00, 32'd6, 32'd7);
        run(2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_busy", 32'(busy), 32'd0);
        expect_hilo("arst", 32'h0, 32'h0);
        reset = 1'b0;
        run(MC + 1);
        expect_hilo("arst_after", 32'h0, 32'h0);

        // start beats a same-cycle mthi, then back-to-back launch
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        hilo_we = 1'b1; hilo_wsel = 1'b1; wdata = 32'h55;
        cycle();
        start = 1'b0; hilo_we = 1'b0;
        run(MC);
        expect_hilo("prio", 32'h0, 32'd4);
        launch(2'b01, 32'd3, 32'd5);
        run(MC);
        expect_hilo("b2b", 32'h0, 32'd15);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int sel;
            start     = ($urandom_range(0, 3) == 0);
            op        = 2'($urandom_range(0, 3));
            a         = $urandom;
            b         = $urandom;
            sel       = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 9));
            hilo_we   = ($urandom_range(0, 2) == 0);
            hilo_wsel = 1'($urandom_range(0, 1));
            wdata     = $urandom;
            rd_sel    = 1'($urandom_range(0, 1));
            cycle();
        end
        start = 1'b0; hilo_we = 1'b0;
        run(DC + 1);
        expect_hilo("rand_end", m_hi, m_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
